// File: rtl/latency_mem.sv
// rtl/latency_mem.sv - fixed-latency single-port word memory serving one request at a time
// Optional feature macro: LATENCY_MEM_RANGE_CHECK_EN adds mem_res_err for out-of-range addresses.
module latency_mem #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              mem_req_valid,
    input  logic              mem_req_rw,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_data,
    output logic              mem_res_ready,
    output logic [DATA_W-1:0] mem_res_data,
`ifdef LATENCY_MEM_RANGE_CHECK_EN
    output logic              mem_res_err,
`endif
    output logic              mem_busy
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              rw_q;
    logic              oor_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_q;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [ADDR_W-1:0] word_addr;
    logic [IDX_W-1:0]  req_idx;
    logic              req_oor;
    logic              accept;
    logic              unused_bits;

    assign word_addr = mem_req_addr >> OFF_W;
    assign req_idx   = word_addr[IDX_W-1:0];
    assign accept    = (state == IDLE) && mem_req_valid;

`ifdef LATENCY_MEM_RANGE_CHECK_EN
    assign req_oor = |word_addr[ADDR_W-1:IDX_W];
`else
    assign req_oor = 1'b0;
`endif

    // Write data is committed at acceptance, so the latched copy is kept only for visibility.
    assign unused_bits = ^{word_addr, data_q};

    always_ff @(posedge clk) begin
        if (n_rst && accept && mem_req_rw && !req_oor) begin
            mem[req_idx] <= mem_req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rw_q          <= 1'b0;
            oor_q         <= 1'b0;
            idx_q         <= '0;
            data_q        <= '0;
            mem_res_ready <= 1'b0;
            mem_res_data  <= '0;
            mem_busy      <= 1'b0;
`ifdef LATENCY_MEM_RANGE_CHECK_EN
            mem_res_err   <= 1'b0;
`endif
        end else begin
            mem_res_ready <= 1'b0;
`ifdef LATENCY_MEM_RANGE_CHECK_EN
            mem_res_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // busy stays up through the ready cycle and drops only when nothing new arrives
                    mem_busy <= mem_req_valid;
                    if (mem_req_valid) begin
                        rw_q   <= mem_req_rw;
                        oor_q  <= req_oor;
                        idx_q  <= req_idx;
                        data_q <= mem_req_data;
                        cnt    <= CNT_LOAD;
                        state  <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    mem_res_ready <= 1'b1;
                    mem_res_data  <= (rw_q || oor_q) ? '0 : mem[idx_q];
`ifdef LATENCY_MEM_RANGE_CHECK_EN
                    mem_res_err   <= oor_q;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
